// File: rtl/instr_fetch.sv
// instr_fetch: MIPS instruction-fetch stage.
// Keeps the PC, sends one instruction-memory request at a time, latches the
// returned word into the IR and splits it into decode fields. Jump and jr
// redirects are applied in the cycle that decode consumes the IR.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 8,
    parameter int          TO_W     = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        ir_ready,
    input  logic        jump_en,
    input  logic        jr_en,
    input  logic [31:0] jr_addr,
    output logic        ir_valid,
    output logic [5:0]  Opcode,
    output logic [5:0]  Function,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16,
    output logic [31:0] pc_out,
    output logic        align_err,
    output logic        fetch_retry
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    // Last WAIT cycle before the request is abandoned and reissued.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [1:0]      state;
    logic [31:0]     pc;
    logic [31:0]     ir;
    logic [TO_W-1:0] wait_cnt;

    // Request strobe and address come straight from registers, so there is
    // no combinational path from any input to these outputs.
    assign imem_req  = (state == S_REQ);
    assign imem_addr = pc;

    // Decode fields are fixed slices of the instruction register.
    assign Opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign imm16    = ir[15:0];
    assign Function = ir[5:0];

    // Fetch state machine, PC/IR update, redirect handling and status pulses.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples the pre-edge values; blocking writes would let later lines
        // see this cycle's updates and break the pc_out <= pc / pc <= pc+4 pair.
        if (reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            ir          <= '0;
            pc_out      <= '0;
            ir_valid    <= 1'b0;
            align_err   <= 1'b0;
            fetch_retry <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            align_err   <= 1'b0;
            fetch_retry <= 1'b0;
            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        // A response on the timeout cycle still wins.
                        ir       <= imem_rdata;
                        pc_out   <= pc;
                        pc       <= pc + 32'd4;
                        ir_valid <= 1'b1;
                        wait_cnt <= '0;
                        state    <= S_HOLD;
                    end else if (wait_cnt == TO_LAST) begin
                        fetch_retry <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= S_REQ;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                S_HOLD: begin
                    if (ir_ready) begin
                        ir_valid <= 1'b0;
                        state    <= S_REQ;
                        if (jr_en) begin
                            pc        <= {jr_addr[31:2], 2'b00};
                            align_err <= |jr_addr[1:0];
                        end else if (jump_en) begin
                            // pc already points at pc_out+4 here.
                            pc <= {pc[31:28], ir[25:0], 2'b00};
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
